bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_LOCK, default 4: max consecutive grants to m1 while m1_lock is high.
REQ-002 SHALL have port cpu_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port cpu_rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports m0_req / m0_wen  input  1 each  CPU data-port request / write enable.
REQ-005 SHALL have ports m0_addr / m0_wdata  input  32 each  CPU access address / write data.
REQ-006 SHALL have ports m0_ack  output  1 and m0_rdata  output  32  CPU completion pulse / read data.
REQ-007 SHALL have ports m1_req, m1_wen, m1_addr, m1_wdata, m1_ack, m1_rdata  same directions and widths as m0; loader/debug port.
REQ-008 SHALL have port m1_lock  input  1  m1 requests priority for back-to-back transactions.
REQ-009 SHALL have ports Bus_addr  output  32, Bus_wen  output  1, Bus_wdata  output  32  to bridge.
REQ-010 SHALL have port Bus_rdata  input  32  bridge read data, valid the cycle after Bus_addr is presented.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; every transaction occupies exactly 3 cycles.
REQ-013 In IDLE with any req high, SHALL select a winner, latch its addr/wdata/wen, and enter ACCESS next cycle.
REQ-014 In IDLE with no req high, SHALL remain in IDLE.
REQ-015 In ACCESS, SHALL drive latched addr/wdata on Bus_addr/Bus_wdata and assert Bus_wen for exactly this one cycle if latched wen = 1.
REQ-016 In RESP, SHALL register Bus_rdata into the winner's rdata output and pulse that port's ack for exactly one cycle; Bus_wen = 0.
REQ-017 Latency: req sampled in IDLE at cycle N -> Bus_wen/addr valid at N+1 -> ack at N+2.
REQ-018 Arbitration, in priority order: (a) m1_lock=1 and m1_req=1 and lock_cnt<MAX_LOCK -> m1; (b) single requester wins; (c) both requesting -> port other than last_gnt wins (round robin).
REQ-019 lock_cnt SHALL increment on each m1 grant with m1_lock=1, saturate at MAX_LOCK, and clear on any m0 grant or any IDLE cycle with m1_lock=0.
REQ-020 When lock_cnt = MAX_LOCK and m0_req = 1, m0 SHALL win, so m0 is never starved longer than MAX_LOCK transactions.
REQ-021 Requesters SHALL hold req until ack; the arbiter SHALL NOT re-grant a port in the IDLE cycle immediately after its ack if the other port is requesting.
REQ-022 A req dropped after the grant SHALL still complete with an ack; latched values SHALL be used.
REQ-023 For a write, m*_rdata SHALL still be updated from Bus_rdata in RESP.
REQ-024 Bus_addr/Bus_wdata SHALL hold their last value outside ACCESS; m*_rdata SHALL hold until that port's next ack.
REQ-025 Write data SHALL be 32-bit word only; no byte enables, no address decoding.

Reset
REQ-026 With cpu_rst high at a rising edge: state=IDLE, last_gnt=1 (m0 wins first tie), lock_cnt=0.
REQ-027 Reset values: all outputs, Bus_addr, Bus_wdata, m0_rdata, m1_rdata = 0; Bus_wen, m0_ack, m1_ack, busy = 0.
REQ-028 Reset in ACCESS or RESP SHALL abort the transaction with no ack issued.

Structure
REQ-029 FSM state encoding and port-index constants (PORT_CPU=0, PORT_LDR=1) SHALL live in the shared defines header.
REQ-030 Arbitration decision (REQ-018..020) SHALL be a combinational sub-module rr_arbiter2; FSM, latches and lock counter SHALL stay in bus_arbiter.

Verification
REQ-031 The bench SHALL cover: m0 read 0x0000_0010 alone, Bus_rdata=0xDEAD_BEEF in cycle 2 -> m0_ack at cycle 2, m0_rdata=0xDEAD_BEEF; m1_ack stays 0.
REQ-032 The bench SHALL cover: m0 and m1 both request from reset -> grant order m0, m1, m0 while both stay requesting; 3 cycles per ack.
REQ-033 The bench SHALL cover: m1_lock=1 with 6 m1 requests and m0 requesting -> 4 m1 acks, then 1 m0 ack, then m1 resumes.
REQ-034 The bench SHALL cover: m1 write addr 0x100, wdata 0x55AA -> Bus_wen high for exactly one cycle with Bus_addr=0x100, Bus_wdata=0x55AA.
REQ-035 The bench SHALL cover: cpu_rst asserted in ACCESS -> no ack; next cycle Bus_wen=0, busy=0; a fresh request is served normally.
REQ-036 The bench SHALL cover: m0_req dropped the cycle after grant -> m0_ack still pulses at N+2.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared FSM state codes, port indices and latched-transfer type for bus_arbiter
package bus_arbiter_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;
  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-port winner select (lock priority, single requester, round robin)
// ports: req0/req1 requests, lock = m1_lock, last_gnt = previous winner, lock_cnt = locked m1 streak, gnt = winner index
module rr_arbiter2
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 4,
  parameter int CW = $clog2(MAX_LOCK + 1)
) (
  input  logic          req0,
  input  logic          req1,
  input  logic          lock,
  input  logic          last_gnt,
  input  logic [CW-1:0] lock_cnt,
  output logic          gnt
);
  // once the locked streak saturates, a tie falls to round robin, which hands the bus to m0
  always_comb gnt = (lock && req1 && lock_cnt < CW'(MAX_LOCK)) ? PORT_LDR :
                    (req0 && req1) ? ~last_gnt : req1;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master (CPU m0, loader m1) single-transaction arbiter onto a bridge bus, 3 cycles per transfer
// ports: cpu_clk/cpu_rst; m0_*/m1_* master req/wen/addr/wdata in, ack/rdata out; m1_lock priority request;
//        Bus_addr/Bus_wen/Bus_wdata to bridge, Bus_rdata from bridge; busy high outside IDLE
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 4
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        m0_req,
  input  logic        m0_wen,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wen,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  input  logic        m1_lock,
  output logic [31:0] Bus_addr,
  output logic        Bus_wen,
  output logic [31:0] Bus_wdata,
  input  logic [31:0] Bus_rdata,
  output logic        busy
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic [1:0] state;
  logic gnt, win, any_req;
  logic [CW-1:0] lock_cnt;
  xfer_t xfer;
  assign any_req = m0_req | m1_req;
  // gnt doubles as last_gnt: it only changes on a grant, and its reset value makes m0 win the first tie
  rr_arbiter2 #(.MAX_LOCK(MAX_LOCK)) u_arb (
    .req0(m0_req),
    .req1(m1_req),
    .lock(m1_lock),
    .last_gnt(gnt),
    .lock_cnt(lock_cnt),
    .gnt(win)
  );
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state    <= ST_IDLE;
      gnt      <= PORT_LDR;
      lock_cnt <= '0;
      xfer     <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (state == ST_IDLE) begin
      if (any_req) begin
        state <= ST_ACCESS;
        gnt   <= win;
        xfer  <= win ? '{m1_wen, m1_addr, m1_wdata} : '{m0_wen, m0_addr, m0_wdata};
      end
      if (!m1_lock || (any_req && win == PORT_CPU)) lock_cnt <= '0;
      else if (any_req && lock_cnt != CW'(MAX_LOCK)) lock_cnt <= lock_cnt + 1'b1;
    end else if (state == ST_ACCESS) begin
      state <= ST_RESP;
    end else begin
      state <= ST_IDLE;
      if (state == ST_RESP && gnt == PORT_LDR) m1_rdata <= Bus_rdata;
      if (state == ST_RESP && gnt == PORT_CPU) m0_rdata <= Bus_rdata;
    end
  end
  always_comb begin
    busy      = state != ST_IDLE;
    Bus_addr  = xfer.addr;
    Bus_wdata = xfer.wdata;
    Bus_wen   = state == ST_ACCESS && xfer.wen;
    m0_ack    = state == ST_RESP && gnt == PORT_CPU;
    m1_ack    = state == ST_RESP && gnt == PORT_LDR;
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus random traffic checked against a transaction-level model
module tb_bus_arbiter;
  localparam int MAX_LOCK = 4;
  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b1;
  logic req[2], wen[2];
  logic [31:0] addr[2], wdata[2];
  logic m1_lock = 1'b0;
  logic [31:0] Bus_rdata = '0;
  logic m0_ack, m1_ack, Bus_wen, busy;
  logic [31:0] m0_rdata, m1_rdata, Bus_addr, Bus_wdata;
  bus_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
    .cpu_clk(cpu_clk),
    .cpu_rst(cpu_rst),
    .m0_req(req[0]),
    .m0_wen(wen[0]),
    .m0_addr(addr[0]),
    .m0_wdata(wdata[0]),
    .m0_ack(m0_ack),
    .m0_rdata(m0_rdata),
    .m1_req(req[1]),
    .m1_wen(wen[1]),
    .m1_addr(addr[1]),
    .m1_wdata(wdata[1]),
    .m1_ack(m1_ack),
    .m1_rdata(m1_rdata),
    .m1_lock(m1_lock),
    .Bus_addr(Bus_addr),
    .Bus_wen(Bus_wen),
    .Bus_wdata(Bus_wdata),
    .Bus_rdata(Bus_rdata),
    .busy(busy)
  );
  always #5 cpu_clk = ~cpu_clk;
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // transaction-level model: a grant at cycle s occupies s+1 (bus) and s+2 (ack), bus free again at s+3
  int k = 0;
  int t_start = -10;
  int streak = 0;
  logic t_port = 1'b0, t_wen = 1'b0, m_last = 1'b1;
  logic [31:0] t_addr = '0, t_wdata = '0, m_baddr = '0, m_bwdata = '0;
  logic [31:0] m_rd[2];
  logic e_acc, e_resp;
  int ack_log[$];
  task automatic model_update();
    if (cpu_rst) begin
      t_start = -10;
      m_last = 1'b1;
      streak = 0;
      m_rd[0] = '0;
      m_rd[1] = '0;
      m_baddr = '0;
      m_bwdata = '0;
    end else begin
      if (k == t_start + 2) m_rd[t_port] = Bus_rdata;
      if (k >= t_start + 3) begin
        if (!m1_lock) streak = 0;
        if (req[0] || req[1]) begin
          if (m1_lock && req[1] && streak < MAX_LOCK) t_port = 1'b1;
          else if (req[0] && req[1]) t_port = !m_last;
          else t_port = req[1];
          streak = (t_port && m1_lock) ? ((streak + 1 > MAX_LOCK) ? MAX_LOCK : streak + 1) : 0;
          t_wen = wen[t_port];
          t_addr = addr[t_port];
          t_wdata = wdata[t_port];
          m_baddr = t_addr;
          m_bwdata = t_wdata;
          m_last = t_port;
          t_start = k;
        end
      end
    end
  endtask
  task automatic check_outputs();
    e_acc = (k == t_start + 1);
    e_resp = (k == t_start + 2);
    chk("busy", busy, e_acc || e_resp);
    chk("bus_wen", Bus_wen, e_acc && t_wen);
    chk("m0_ack", m0_ack, e_resp && !t_port);
    chk("m1_ack", m1_ack, e_resp && t_port);
    chk("bus_addr", Bus_addr, m_baddr);
    chk("bus_wdata", Bus_wdata, m_bwdata);
    chk("m0_rdata", m0_rdata, m_rd[0]);
    chk("m1_rdata", m1_rdata, m_rd[1]);
    if (m0_ack === 1'b1) ack_log.push_back(0);
    if (m1_ack === 1'b1) ack_log.push_back(1);
  endtask
  task automatic cyc();
    model_update();
    @(negedge cpu_clk);
    k++;
    check_outputs();
  endtask
  task automatic rst_seq();
    cpu_rst = 1'b1;
    req[0] = 1'b0;
    req[1] = 1'b0;
    m1_lock = 1'b0;
    cyc();
    cyc();
    cpu_rst = 1'b0;
  endtask
  task automatic set_req(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    req[p] = 1'b1;
    wen[p] = w;
    addr[p] = a;
    wdata[p] = d;
  endtask
  int exp2[3] = '{0, 1, 0};
  int exp3[7] = '{1, 1, 1, 1, 0, 1, 1};
  int n1;
  bit pend[2];
  initial begin
    m_rd[0] = '0;
    m_rd[1] = '0;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0;
      wen[p] = 1'b0;
      addr[p] = '0;
      wdata[p] = '0;
    end
    rst_seq();
    set_req(0, 1'b0, 32'h0000_0010, 32'h0);
    cyc();
    chk("t1_addr", Bus_addr, 32'h0000_0010);
    cyc();
    chk("t1_ack0", m0_ack, 1);
    chk("t1_ack1", m1_ack, 0);
    req[0] = 1'b0;
    Bus_rdata = 32'hDEAD_BEEF;
    cyc();
    chk("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
    rst_seq();
    set_req(0, 1'b0, 32'h200, 32'h0);
    set_req(1, 1'b0, 32'h300, 32'h0);
    ack_log.delete();
    repeat (9) cyc();
    chk("t2_nacks", ack_log.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("t2_order%0d", i), i < ack_log.size() ? ack_log[i] : 99, exp2[i]);
    rst_seq();
    m1_lock = 1'b1;
    set_req(0, 1'b0, 32'h400, 32'h0);
    set_req(1, 1'b0, 32'h500, 32'h0);
    ack_log.delete();
    n1 = 0;
    repeat (24) begin
      cyc();
      if (m1_ack === 1'b1) begin
        n1++;
        if (n1 == 6) req[1] = 1'b0;
      end
    end
    for (int i = 0; i < 7; i++) chk($sformatf("t3_order%0d", i), i < ack_log.size() ? ack_log[i] : 99, exp3[i]);
    rst_seq();
    set_req(1, 1'b1, 32'h100, 32'h55AA);
    cyc();
    chk("t4_wen", Bus_wen, 1);
    chk("t4_addr", Bus_addr, 32'h100);
    chk("t4_wdata", Bus_wdata, 32'h55AA);
    cyc();
    chk("t4_wen_off", Bus_wen, 0);
    req[1] = 1'b0;
    cyc();
    rst_seq();
    set_req(0, 1'b1, 32'h600, 32'h1234);
    cyc();
    chk("t5_busy_acc", busy, 1);
    cpu_rst = 1'b1;
    cyc();
    chk("t5_wen", Bus_wen, 0);
    chk("t5_busy", busy, 0);
    chk("t5_noack", m0_ack, 0);
    cpu_rst = 1'b0;
    cyc();
    cyc();
    chk("t5_fresh_ack", m0_ack, 1);
    req[0] = 1'b0;
    cyc();
    rst_seq();
    set_req(0, 1'b0, 32'h700, 32'h0);
    cyc();
    req[0] = 1'b0;
    addr[0] = 32'hFFFF_0000;
    cyc();
    chk("t6_ack", m0_ack, 1);
    cyc();
    rst_seq();
    pend[0] = 0;
    pend[1] = 0;
    repeat (3000) begin
      for (int p = 0; p < 2; p++) if (pend[p] && e_resp && t_port == p[0]) pend[p] = 0;
      cpu_rst = ($urandom_range(0, 199) == 0);
      if (cpu_rst) begin
        pend[0] = 0;
        pend[1] = 0;
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if (!cpu_rst && $urandom_range(0, 9) < 4) begin
            pend[p] = 1;
            set_req(p, 1'($urandom), $urandom, $urandom);
          end else req[p] = 1'b0;
        end else if (e_acc && t_port == p[0] && $urandom_range(0, 3) == 0) begin
          req[p] = 1'b0;
          addr[p] = $urandom;
          wdata[p] = $urandom;
        end
      end
      if ($urandom_range(0, 9) == 0) m1_lock = ~m1_lock;
      Bus_rdata = $urandom;
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
